uart_tx_axil_slave: RTL and testbench

UART_TX_AXIL_SLAVE -- requirements
Module: uart_tx_axil_slave

---
 rtl/uart_axil_pkg.sv | 33 +++
 rtl/uart_tx_axil_slave_if.sv | 32 +++
 rtl/uart_tx_serializer.sv | 108 ++++++++++
 rtl/uart_tx_axil_slave.sv | 138 +++++++++++++
 tb/tb_uart_tx_axil_slave.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_axil_pkg.sv
// Shared definitions for the AXI4-Lite UART transmitter: register map, STATUS layout,
// response codes and serializer state type.
package uart_axil_pkg;

    localparam logic [7:0] AddrStatus = 8'h10;
    localparam logic [7:0] AddrTxData = 8'h30;

    localparam int unsigned StatusFullBit   = 4;
    localparam int unsigned StatusEmptyBit  = 3;
    localparam int unsigned StatusActiveBit = 1;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    function automatic logic [31:0] status_word(input logic full, input logic empty,
                                                input logic active);
        logic [31:0] w;
        w = '0;
        w[StatusFullBit]   = full;
        w[StatusEmptyBit]  = empty;
        w[StatusActiveBit] = active;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_axil_slave_if.sv
// AXI4-Lite bus bundle (32-bit data) between a master and the UART transmitter slave.
interface uart_tx_axil_slave_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Byte-to-serial UART framer, 8N1 by default; defining UART_TX_PARITY_EN inserts an
// even-parity bit between the data bits and the stop bit.
module uart_tx_serializer
    import uart_axil_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       txd,
    output logic       active
);

    localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        bit_done;

    assign bit_done = (cnt_q == LastCnt);
    // Accepting during the last stop cycle gives back-to-back frames with no idle gap.
    assign ready    = (state_q == StIdle) || (state_q == StStop && bit_done);
    assign active   = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;

        if (state_q != StIdle) begin
            cnt_d = bit_done ? 16'd0 : cnt_q + 16'd1;
        end

        unique case (state_q)
            StIdle: ;
            StStart: begin
                if (bit_done) state_d = StData;
            end
            StData: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (bit_done) state_d = StStop;
            end
            StStop: begin
                if (bit_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (valid && ready) begin
            state_d = StStart;
            cnt_d   = 16'd0;
            bit_d   = 3'd0;
            shift_d = data;
            par_d   = ^data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        txd = 1'b1;
        unique case (state_q)
            StIdle:   txd = 1'b1;
            StStart:  txd = 1'b0;
            StData:   txd = shift_q[0];
            StParity: txd = par_q;
            StStop:   txd = 1'b1;
            default:  txd = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_tx_axil_slave.sv
// AXI4-Lite slave feeding a TX FIFO and UART serializer. STATUS at 0x10, TX_DATA at 0x30.
// UART_TX_PARITY_EN (in uart_tx_serializer) selects 8E1 framing instead of 8N1.
module uart_tx_axil_slave
    import uart_axil_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT       = 868,
    parameter int unsigned FIFO_DEPTH         = 16,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 12
) (
    input  logic                s00_axi_aclk,
    input  logic                s00_axi_areset,
    uart_tx_axil_slave_if.slave s00_axi,
    output logic                uart_txd,
    output logic                tx_busy
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic            awready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]      bresp_q, rresp_q;
    logic [31:0]     rdata_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;

    logic        fifo_full, fifo_empty, push, pop;
    logic        wr_hs, rd_hs;
    logic [1:0]  wr_resp, rd_resp;
    logic [31:0] rd_data;
    logic        ser_ready, ser_active;
    logic [7:0]  aw_off, ar_off;

    assign aw_off     = s00_axi.awaddr[7:0];
    assign ar_off     = s00_axi.araddr[7:0];
    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign wr_hs      = awready_q && s00_axi.awvalid && s00_axi.wvalid;
    assign rd_hs      = arready_q && s00_axi.arvalid;
    assign pop        = !fifo_empty && ser_ready;

    logic unused_bits;
    assign unused_bits = ^{s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:8],
                           s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:8],
                           s00_axi.wdata[31:8], s00_axi.wstrb[3:1]};

    // Full is the registered flag, so a push into a full FIFO is refused even if a pop
    // happens in the same cycle.
    always_comb begin
        wr_resp = RespOkay;
        push    = 1'b0;
        if (aw_off == AddrTxData) begin
            if (s00_axi.wstrb[0]) begin
                if (fifo_full) wr_resp = RespSlverr;
                else           push    = wr_hs;
            end
        end else if (aw_off != AddrStatus) begin
            wr_resp = RespSlverr;
        end
    end

    always_comb begin
        rd_data = 32'd0;
        rd_resp = RespOkay;
        if (ar_off == AddrStatus) begin
            rd_data = status_word(fifo_full, fifo_empty, ser_active);
        end else if (ar_off != AddrTxData) begin
            rd_resp = RespSlverr;
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RespOkay;
            rdata_q   <= 32'd0;
        end else begin
            awready_q <= !awready_q && s00_axi.awvalid && s00_axi.wvalid && !bvalid_q;
            if (wr_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (s00_axi.bready) begin
                bvalid_q <= 1'b0;
            end
            arready_q <= !arready_q && s00_axi.arvalid && !rvalid_q;
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_resp;
            end else if (s00_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (push) mem_q[wr_ptr_q] <= s00_axi.wdata[7:0];
    end

    assign s00_axi.awready = awready_q;
    assign s00_axi.wready  = awready_q;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = bresp_q;
    assign s00_axi.arready = arready_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rresp   = rresp_q;
    assign s00_axi.rdata   = rdata_q;
    assign tx_busy         = ser_active || !fifo_empty;

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serializer (
        .clk   (s00_axi_aclk),
        .rst   (s00_axi_areset),
        .data  (mem_q[rd_ptr_q]),
        .valid (!fifo_empty),
        .ready (ser_ready),
        .txd   (uart_txd),
        .active(ser_active)
    );

endmodule

// File: tb/tb_uart_tx_axil_slave.sv
// Scoreboard bench for uart_tx_axil_slave (CLKS_PER_BIT=16, FIFO_DEPTH=16); honours
// UART_TX_PARITY_EN for frame length and parity expectations.
module tb_uart_tx_axil_slave;

    localparam int unsigned Cpb = 16;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned Par = 1;
`else
    localparam int unsigned Par = 0;
`endif
    localparam int unsigned NBits   = 10 + Par;
    localparam int unsigned FrameCy = Cpb * NBits;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_txd, tx_busy;

    uart_tx_axil_slave_if #(.ADDR_WIDTH(12)) s00_axi ();

    uart_tx_axil_slave #(
        .CLKS_PER_BIT      (Cpb),
        .FIFO_DEPTH        (16),
        .C_S_AXI_ADDR_WIDTH(12)
    ) dut (
        .s00_axi_aclk  (clk),
        .s00_axi_areset(rst),
        .s00_axi       (s00_axi),
        .uart_txd      (uart_txd),
        .tx_busy       (tx_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int skip_frames = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [7:0]  txq[$];
    int          starts[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // B channel scoreboard
    always begin
        @(negedge clk);
        #1;
        if (!rst && s00_axi.bvalid && s00_axi.bready) begin
            if (bq.size() == 0) check("b_unexpected", 32'd1, 32'd0);
            else check("bresp", 32'(s00_axi.bresp), 32'(bq.pop_front()));
        end
    end

    // R channel scoreboard
    always begin
        logic [33:0] e;
        @(negedge clk);
        #1;
        if (!rst && s00_axi.rvalid && s00_axi.rready) begin
            if (rq.size() == 0) begin
                check("r_unexpected", 32'd1, 32'd0);
            end else begin
                e = rq.pop_front();
                check("rdata", s00_axi.rdata, e[31:0]);
                check("rresp", 32'(s00_axi.rresp), 32'(e[33:32]));
            end
        end
    end

    // Line receiver: mid-bit sampling, compares against bytes queued by accepted writes
    always begin
        logic [7:0] got;
        logic       stop_b, par_b;
        @(negedge clk);
        if (!rst && uart_txd == 1'b0) begin
            starts.push_back(cyc);
            par_b = 1'b0;
            repeat (Cpb / 2 - 1) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (Cpb) @(negedge clk);
                got[i] = uart_txd;
            end
            if (Par != 0) begin
                repeat (Cpb) @(negedge clk);
                par_b = uart_txd;
            end
            repeat (Cpb) @(negedge clk);
            stop_b = uart_txd;
            repeat (Cpb / 2) @(negedge clk);
            if (skip_frames > 0) begin
                skip_frames--;
            end else if (txq.size() == 0) begin
                check("rx_unexpected", 32'd1, 32'd0);
            end else begin
                check("rx_byte", 32'(got), 32'(txq[0]));
                if (Par != 0) check("rx_parity", 32'(par_b), 32'(^txq[0]));
                check("rx_stop", 32'(stop_b), 32'd1);
                void'(txq.pop_front());
            end
        end
    end

    task automatic aw_w(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit ok;
        @(negedge clk);
        s00_axi.awaddr  = {4'h0, addr};
        s00_axi.wdata   = data;
        s00_axi.wstrb   = strb;
        s00_axi.awvalid = 1'b1;
        s00_axi.wvalid  = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (s00_axi.awready && s00_axi.wready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("aw_timeout", 32'd0, 32'd1);
        @(negedge clk);
        s00_axi.awvalid = 1'b0;
        s00_axi.wvalid  = 1'b0;
    endtask

    task automatic ar(input logic [7:0] addr);
        bit ok;
        @(negedge clk);
        s00_axi.araddr  = {4'h0, addr};
        s00_axi.arvalid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (s00_axi.arready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ar_timeout", 32'd0, 32'd1);
        @(negedge clk);
        s00_axi.arvalid = 1'b0;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp);
        bq.push_back(exp);
        if (addr == 8'h30 && strb[0] && exp == 2'b00) txq.push_back(data[7:0]);
        aw_w(addr, data, strb);
        for (int n = 0; n < 100 && bq.size() != 0; n++) @(negedge clk);
        if (bq.size() != 0) begin
            check("b_timeout", 32'd0, 32'd1);
            bq.delete();
        end
    endtask

    task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        rq.push_back({exp_resp, exp_data});
        ar(addr);
        for (int n = 0; n < 100 && rq.size() != 0; n++) @(negedge clk);
        if (rq.size() != 0) begin
            check("r_timeout", 32'd0, 32'd1);
            rq.delete();
        end
    endtask

    task automatic wait_fall(output bit found);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (uart_txd == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("frame_start", 32'd0, 32'd1);
    endtask

    // Every cycle of every bit must carry the expected level for exactly Cpb cycles
    task automatic sample_frame(input logic [7:0] b);
        logic [11:0] bits;
        bit          found;
        int          ok;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        if (Par != 0) bits[9] = ^b;
        wait_fall(found);
        if (found) begin
            for (int i = 0; i < int'(NBits); i++) begin
                ok = 0;
                for (int c = 0; c < int'(Cpb); c++) begin
                    if (i != 0 || c != 0) @(negedge clk);
                    if (uart_txd == bits[i]) ok++;
                end
                check($sformatf("frame_%0h_bit%0d", b, i), 32'(ok), 32'(Cpb));
            end
            @(negedge clk);
            check("frame_end_busy", 32'(tx_busy), 32'd0);
        end
    endtask

    initial begin
        int   stable;
        bit   found;
        s00_axi.awaddr  = '0;
        s00_axi.awvalid = 1'b0;
        s00_axi.wdata   = '0;
        s00_axi.wstrb   = '0;
        s00_axi.wvalid  = 1'b0;
        s00_axi.bready  = 1'b1;
        s00_axi.araddr  = '0;
        s00_axi.arvalid = 1'b0;
        s00_axi.rready  = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_ready", 32'({s00_axi.awready, s00_axi.wready, s00_axi.arready}), 32'd0);
        check("rst_valid", 32'({s00_axi.bvalid, s00_axi.rvalid}), 32'd0);
        check("rst_resp", 32'({s00_axi.bresp, s00_axi.rresp}), 32'd0);
        check("rst_rdata", s00_axi.rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        axi_read(8'h10, 32'h08, 2'b00);

        fork
            axi_write(8'h30, 32'h55, 4'h1, 2'b00);
            sample_frame(8'h55);
        join
        fork
            axi_write(8'h30, 32'h07, 4'h1, 2'b00);
            sample_frame(8'h07);
        join

        axi_write(8'h44, 32'hDEAD_BEEF, 4'hF, 2'b10);
        axi_read(8'h44, 32'h0, 2'b10);
        axi_write(8'h10, 32'hFF, 4'hF, 2'b00);
        axi_write(8'h30, 32'h99, 4'h2, 2'b00);
        repeat (2) @(negedge clk);
        check("no_push_busy", 32'(tx_busy), 32'd0);
        axi_read(8'h10, 32'h08, 2'b00);

        // First write is popped straight away, 16 more fill the FIFO, the next is refused
        starts.delete();
        for (int i = 0; i < 18; i++) begin
            axi_write(8'h30, 32'(i * 13 + 1), 4'h1, (i < 17) ? 2'b00 : 2'b10);
        end
        axi_read(8'h10, 32'h12, 2'b00);
        for (int n = 0; n < 4000 && (txq.size() != 0 || tx_busy); n++) @(negedge clk);
        check("drain_left", 32'(txq.size()), 32'd0);
        check("drain_frames", 32'(starts.size()), 32'd17);
        if (starts.size() >= 17) begin
            check("b2b_gap_first", 32'(starts[1] - starts[0]), 32'(FrameCy));
            check("b2b_gap_last", 32'(starts[16] - starts[15]), 32'(FrameCy));
        end

        // B held with bready low; a second write must not be taken meanwhile
        s00_axi.bready = 1'b0;
        bq.push_back(2'b10);
        aw_w(8'h44, 32'h1, 4'hF);
        s00_axi.awaddr  = 12'h030;
        s00_axi.wdata   = 32'hAA;
        s00_axi.wstrb   = 4'h1;
        s00_axi.awvalid = 1'b1;
        s00_axi.wvalid  = 1'b1;
        stable = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (s00_axi.bvalid && s00_axi.bresp == 2'b10 && !s00_axi.awready && !s00_axi.wready)
                stable++;
        end
        check("b_hold", 32'(stable), 32'd5);
        s00_axi.awvalid = 1'b0;
        s00_axi.wvalid  = 1'b0;
        @(negedge clk);
        s00_axi.bready = 1'b1;
        for (int n = 0; n < 20 && bq.size() != 0; n++) @(negedge clk);
        check("b_hold_done", 32'(bq.size()), 32'd0);

        s00_axi.rready = 1'b0;
        rq.push_back({2'b00, 32'h08});
        ar(8'h10);
        s00_axi.araddr  = 12'h044;
        s00_axi.arvalid = 1'b1;
        stable = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (s00_axi.rvalid && s00_axi.rdata == 32'h08 && s00_axi.rresp == 2'b00 &&
                !s00_axi.arready)
                stable++;
        end
        check("r_hold", 32'(stable), 32'd5);
        s00_axi.arvalid = 1'b0;
        @(negedge clk);
        s00_axi.rready = 1'b1;
        for (int n = 0; n < 20 && rq.size() != 0; n++) @(negedge clk);
        check("r_hold_done", 32'(rq.size()), 32'd0);

        // Reset in the middle of data bit 3 of 0xA5 (bit 3 = 0)
        fork
            axi_write(8'h30, 32'hA5, 4'h1, 2'b00);
            wait_fall(found);
        join
        if (found) begin
            repeat (Cpb * 4 + Cpb / 2 - 2) @(negedge clk);
            check("pre_rst_bit3", 32'(uart_txd), 32'd0);
            txq.delete();
            skip_frames = 1;
            rst = 1'b1;
            @(negedge clk);
            check("rst_abort_txd", 32'(uart_txd), 32'd1);
            check("rst_abort_busy", 32'(tx_busy), 32'd0);
            rst = 1'b0;
            @(negedge clk);
            axi_read(8'h10, 32'h08, 2'b00);
        end

        repeat (FrameCy + 40) @(negedge clk);
        check("end_txq", 32'(txq.size()), 32'd0);
        check("end_txd", 32'(uart_txd), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
